// File: rtl/stream_demux_n.sv
// -----------------------------------------------------------------------------
// stream_demux_n
//   Routes one valid/ready input stream to one of N_OUT output streams chosen
//   by in_sel. Each output channel owns a one-entry register, so a beat
//   appears on its channel exactly one cycle after it is accepted. With
//   PKT_MODE=1 the route chosen on the first beat of a packet is held until
//   the in_last beat. Beats aimed at a channel that does not exist are
//   swallowed, and err_sel flags them.
//
// Parameters
//   WIDTH     data width per channel
//   N_OUT     number of output channels (2..16)
//   SEL_W     select width, >= clog2(N_OUT)
//   INACTIVE  value shown on out_data of any channel whose out_valid is 0
//   PKT_MODE  1: route locked per packet, 0: route chosen per beat
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    input beat data
//   in_sel     target channel, sampled when a beat is accepted
//   in_last    last beat of a packet (only used when PKT_MODE=1)
//   in_valid   input beat present
//   in_ready   block accepts a beat this cycle (combinational)
//   out_data   channel k data in bits [k*WIDTH +: WIDTH]
//   out_valid  channel k holds a beat
//   out_ready  consumer k takes its beat
//   busy       high while a packet is locked or being dropped
//   err_sel    one-cycle pulse after a beat with an out-of-range route
// -----------------------------------------------------------------------------
module stream_demux_n #(
    parameter int               WIDTH    = 8,
    parameter int               N_OUT    = 4,
    parameter int               SEL_W    = 2,
    parameter logic [WIDTH-1:0] INACTIVE = '0,
    parameter bit               PKT_MODE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   busy,
    output logic                   err_sel
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOCK = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // One extra bit so N_OUT == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] N_OUT_C = (SEL_W + 1)'(N_OUT);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   lock_sel_q, lock_sel_d;
    logic [N_OUT-1:0]   out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   data_q [N_OUT];
    logic [WIDTH-1:0]   data_d [N_OUT];

    logic [SEL_W-1:0]   route;
    logic               route_ok;
    logic [N_OUT-1:0]   route_hot;
    logic               ch_free;
    logic               accept;
    logic               fill;

    // -------------------------------------------------------------------------
    // Route selection and handshake
    // -------------------------------------------------------------------------
    always_comb begin
        route     = (state_q == S_LOCK) ? lock_sel_q : in_sel;
        route_ok  = ({1'b0, route} < N_OUT_C);
        route_hot = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (route == SEL_W'(k)) begin
                route_hot[k] = 1'b1;
            end
        end
        // A full channel that is draining this cycle can take the new beat
        // in the same cycle, so a streaming consumer sees no bubbles.
        ch_free  = |(route_hot & (~out_valid_q | out_ready));
        // Dropped beats never need space, so they are always accepted.
        in_ready = (state_q == S_DROP) || !route_ok || ch_free;
        accept   = in_valid && in_ready;
        fill     = accept && route_ok && (state_q != S_DROP);
    end

    // -------------------------------------------------------------------------
    // Channel registers: drain on out_ready, refill from the accepted beat.
    // Only the addressed channel changes; the others keep their contents.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            out_valid_d[k] = (out_valid_q[k] && !out_ready[k]) || (fill && route_hot[k]);
            data_d[k]      = (fill && route_hot[k]) ? in_data : data_q[k];
        end
        // Inside a dropped packet only the first beat is reported.
        err_d = accept && !route_ok && (state_q != S_DROP);
    end

    // -------------------------------------------------------------------------
    // Packet FSM. With PKT_MODE=0 no transition is ever taken, so the state
    // stays IDLE and the route always follows in_sel.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        if (PKT_MODE && accept) begin
            case (state_q)
                S_IDLE: begin
                    // A single-beat packet (in_last on the first beat) needs no lock.
                    if (!in_last) begin
                        state_d    = route_ok ? S_LOCK : S_DROP;
                        lock_sel_d = in_sel;
                    end
                end
                S_LOCK, S_DROP: begin
                    if (in_last) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers. Control state is reset; channel data is not, because it is
    // masked to INACTIVE whenever the channel is empty.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lock_sel_q  <= '0;
            out_valid_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_sel_q  <= lock_sel_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        out_data = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_data[k*WIDTH +: WIDTH] = out_valid_q[k] ? data_q[k] : INACTIVE;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign err_sel   = err_q;

endmodule

// File: tb/tb_stream_demux_n.sv
module tb_stream_demux_n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: N_OUT=4, per-beat routing, INACTIVE=00
    // Index 1: N_OUT=3, packet mode, INACTIVE=A5 (select value 3 is out of range)
    logic [7:0]  in_data  [2];
    logic [1:0]  in_sel   [2];
    logic        in_last  [2];
    logic        in_valid [2];
    logic [3:0]  ordy_a;
    logic [2:0]  ordy_b;
    logic        rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;
    logic [3:0]  ov_a;
    logic [2:0]  ov_b;
    logic [31:0] od_a;
    logic [23:0] od_b;

    stream_demux_n #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .INACTIVE(8'h00), .PKT_MODE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_sel(in_sel[0]), .in_last(in_last[0]),
        .in_valid(in_valid[0]), .in_ready(rdy_a), .out_data(od_a), .out_valid(ov_a),
        .out_ready(ordy_a), .busy(busy_a), .err_sel(err_a));

    stream_demux_n #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .INACTIVE(8'hA5), .PKT_MODE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_sel(in_sel[1]), .in_last(in_last[1]),
        .in_valid(in_valid[1]), .in_ready(rdy_b), .out_data(od_b), .out_valid(ov_b),
        .out_ready(ordy_b), .busy(busy_b), .err_sel(err_b));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int         N_CH  [2] = '{4, 3};
    logic [7:0] INACT [2] = '{8'h00, 8'hA5};
    bit         PKT   [2] = '{1'b0, 1'b1};

    bit         mv [2][4];
    logic [7:0] md [2][4];
    bit         merr [2];
    bit         in_pkt [2];
    bit         dropping [2];
    int         pkt_route [2];

    function automatic bit get_ordy(int d, int k);
        logic [3:0] t;
        t = (d == 0) ? ordy_a : {1'b0, ordy_b};
        return t[k];
    endfunction

    function automatic bit get_ov(int d, int k);
        logic [3:0] t;
        t = (d == 0) ? ov_a : {1'b0, ov_b};
        return t[k];
    endfunction

    function automatic logic [7:0] get_od(int d, int k);
        logic [31:0] t;
        t = (d == 0) ? od_a : {8'h00, od_b};
        return t[k*8 +: 8];
    endfunction

    function automatic int route_of(int d);
        if (PKT[d] && in_pkt[d] && !dropping[d]) return pkt_route[d];
        return int'(in_sel[d]);
    endfunction

    function automatic bit exp_ready(int d);
        int r;
        r = route_of(d);
        if ((PKT[d] && dropping[d]) || r >= N_CH[d]) return 1'b1;
        return !mv[d][r] || get_ordy(d, r);
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) mv[d][k] = 1'b0;
                merr[d] = 1'b0; in_pkt[d] = 1'b0; dropping[d] = 1'b0;
            end else begin
                int r;
                bit acc, bad, was_drop;
                r        = route_of(d);
                acc      = in_valid[d] && exp_ready(d);
                bad      = (r >= N_CH[d]);
                was_drop = PKT[d] && dropping[d];
                for (int k = 0; k < N_CH[d]; k++)
                    if (mv[d][k] && get_ordy(d, k)) mv[d][k] = 1'b0;
                if (acc && !bad && !was_drop) begin
                    mv[d][r] = 1'b1;
                    md[d][r] = in_data[d];
                end
                merr[d] = acc && bad && !was_drop;
                if (PKT[d] && acc) begin
                    if (in_last[d]) begin
                        in_pkt[d] = 1'b0; dropping[d] = 1'b0;
                    end else if (!in_pkt[d]) begin
                        in_pkt[d] = 1'b1; dropping[d] = bad; pkt_route[d] = r;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N_CH[d]; k++) begin
                check($sformatf("m%0d ch%0d valid", d, k), 32'(get_ov(d, k)), 32'(mv[d][k]));
                check($sformatf("m%0d ch%0d data", d, k), 32'(get_od(d, k)),
                      32'(mv[d][k] ? md[d][k] : INACT[d]));
            end
        end
        check("m0 busy", 32'(busy_a), 32'(1'b0));
        check("m1 busy", 32'(busy_b), 32'(in_pkt[1]));
        check("m0 err_sel", 32'(err_a), 32'(merr[0]));
        check("m1 err_sel", 32'(err_b), 32'(merr[1]));
    endtask

    // Called just after the falling edge with inputs already driven.
    task automatic tick();
        #1;
        if (!rst) begin
            check("m0 in_ready", 32'(rdy_a), 32'(exp_ready(0)));
            check("m1 in_ready", 32'(rdy_b), 32'(exp_ready(1)));
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_sel[d] = 2'd0; in_last[d] = 1'b0; in_data[d] = 8'h00;
        end
    endtask

    task automatic beat_b(input logic [1:0] sel, input logic [7:0] data, input logic last);
        in_valid[1] = 1'b1; in_sel[1] = sel; in_data[1] = data; in_last[1] = last;
    endtask

    // ---------------- directed vectors for the per-beat channel ----------------
    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b1, 2'd0, 8'hA0, 4'b1111, 1'b1, 4'b0001, 32'h000000A0};
        vecs[1] = '{1'b1, 2'd1, 8'hA1, 4'b1111, 1'b1, 4'b0010, 32'h0000A100};
        vecs[2] = '{1'b1, 2'd2, 8'hA2, 4'b1111, 1'b1, 4'b0100, 32'h00A20000};
        vecs[3] = '{1'b1, 2'd3, 8'hA3, 4'b1111, 1'b1, 4'b1000, 32'hA3000000};
        vecs[4] = '{1'b1, 2'd2, 8'hB0, 4'b1011, 1'b1, 4'b0100, 32'h00B00000};
        vecs[5] = '{1'b1, 2'd2, 8'hB1, 4'b1011, 1'b0, 4'b0100, 32'h00B00000};
        vecs[6] = '{1'b1, 2'd1, 8'hC1, 4'b1011, 1'b1, 4'b0110, 32'h00B0C100};
        vecs[7] = '{1'b1, 2'd2, 8'hB1, 4'b1111, 1'b1, 4'b0100, 32'h00B10000};
        vecs[8] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00000000};

        idle_inputs();
        ordy_a = 4'hF; ordy_b = 3'h7;
        rst = 1'b1;
        @(negedge clk);

        // T1: reset
        tick(); tick();
        rst = 1'b0;
        #1;
        check("T1 in_ready a", 32'(rdy_a), 32'(1'b1));
        check("T1 in_ready b", 32'(rdy_b), 32'(1'b1));
        check("T1 out_valid a", 32'(ov_a), 32'h0);
        check("T1 out_valid b", 32'(ov_b), 32'h0);
        check("T1 out_data a", od_a, 32'h00000000);
        check("T1 out_data b", 32'(od_b), 32'h00A5A5A5);
        check("T1 busy b", 32'(busy_b), 32'h0);

        // T2/T3: per-channel routing, stall, pass-through
        for (int i = 0; i < 9; i++) begin
            in_valid[0] = vecs[i].vld; in_sel[0] = vecs[i].sel; in_data[0] = vecs[i].data;
            ordy_a = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(rdy_a), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(ov_a), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d out_data", i), od_a, vecs[i].exp_data);
        end
        idle_inputs();

        // T4: packet lock onto channel 2
        ordy_b = 3'b111;
        beat_b(2'd2, 8'h11, 1'b0); tick();
        check("T4 b1 data", 32'(od_b), 32'h0011A5A5);
        check("T4 b1 busy", 32'(busy_b), 32'h1);
        in_valid[1] = 1'b0; in_sel[1] = 2'd0; tick();
        check("T4 gap valid", 32'(ov_b), 32'h0);
        check("T4 gap busy", 32'(busy_b), 32'h1);
        beat_b(2'd0, 8'h22, 1'b0); tick();
        check("T4 b2 data", 32'(od_b), 32'h0022A5A5);
        check("T4 b2 busy", 32'(busy_b), 32'h1);
        beat_b(2'd1, 8'h33, 1'b1); tick();
        check("T4 b3 data", 32'(od_b), 32'h0033A5A5);
        check("T4 b3 valid", 32'(ov_b), 32'h4);
        check("T4 b3 busy", 32'(busy_b), 32'h0);
        idle_inputs(); tick();

        // T5: out-of-range packet, then a normal one
        beat_b(2'd3, 8'h77, 1'b0); tick();
        check("T5 b1 err", 32'(err_b), 32'h1);
        check("T5 b1 busy", 32'(busy_b), 32'h1);
        check("T5 b1 valid", 32'(ov_b), 32'h0);
        beat_b(2'd0, 8'h78, 1'b0); ordy_b = 3'b000; #1;
        check("T5 drop in_ready", 32'(rdy_b), 32'h1);
        tick();
        check("T5 b2 err", 32'(err_b), 32'h0);
        check("T5 b2 busy", 32'(busy_b), 32'h1);
        check("T5 b2 valid", 32'(ov_b), 32'h0);
        ordy_b = 3'b111;
        beat_b(2'd1, 8'h79, 1'b1); tick();
        check("T5 b3 busy", 32'(busy_b), 32'h0);
        check("T5 b3 valid", 32'(ov_b), 32'h0);
        beat_b(2'd1, 8'h44, 1'b1); tick();
        check("T5 next data", 32'(od_b), 32'h00A544A5);
        check("T5 next err", 32'(err_b), 32'h0);
        beat_b(2'd3, 8'h45, 1'b1); tick();
        check("T5 single bad err", 32'(err_b), 32'h1);
        check("T5 single bad busy", 32'(busy_b), 32'h0);
        idle_inputs(); tick();
        check("T5 err clears", 32'(err_b), 32'h0);

        // T6: reset while locked with channel 1 full
        ordy_b = 3'b000;
        beat_b(2'd1, 8'h55, 1'b0); tick();
        check("T6 lock valid", 32'(ov_b), 32'h2);
        beat_b(2'd0, 8'h56, 1'b0); #1;
        check("T6 stalled", 32'(rdy_b), 32'h0);
        idle_inputs(); rst = 1'b1; tick(); rst = 1'b0;
        check("T6 rst valid", 32'(ov_b), 32'h0);
        check("T6 rst data", 32'(od_b), 32'h00A5A5A5);
        check("T6 rst busy", 32'(busy_b), 32'h0);
        beat_b(2'd0, 8'h66, 1'b1); #1;
        check("T6 ready after rst", 32'(rdy_b), 32'h1);
        tick();
        check("T6 follows sel", 32'(od_b), 32'h00A5A566);
        idle_inputs(); ordy_b = 3'b111; tick();

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid[d] = ($urandom_range(0, 9) < 7);
                in_sel[d]   = 2'($urandom_range(0, 3));
                in_last[d]  = ($urandom_range(0, 3) == 0);
                in_data[d]  = 8'($urandom);
            end
            ordy_a = 4'($urandom_range(0, 15));
            ordy_b = 3'($urandom_range(0, 7));
            rst    = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
